decoder_rr_arbiter: RTL and testbench

// - Round-robin arbiter that shares one resource among 4 requesters and drives the
//   one-hot select through a 2-to-4 decoder with enable.
// - Sits between requesting blocks and the shared resource.
// - Requester holds req until it asserts done. A per-grant hold limit stops any

---
 rtl/decoder_rr_arbiter_pkg.sv | 30 +++
 rtl/decoder_rr_arbiter_grant_decoder.sv | 15 +
 rtl/decoder_rr_arbiter.sv | 100 ++++++++++
 tb/tb_decoder_rr_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
package decoder_rr_arbiter_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // First set request bit found scanning ptr, ptr+1, ... with mod-4 wrap.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic             found;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] win;
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ptr + IDX_W'(i);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/decoder_rr_arbiter_grant_decoder.sv
// Combinational 2-to-4 one-hot decoder with enable.
module grant_decoder
  import decoder_rr_arbiter_pkg::*;
(
  input  logic [IDX_W-1:0]   sel,
  input  logic               en,
  output logic [NUM_REQ-1:0] out
);

  always_comb begin
    out = '0;
    if (en) out[sel] = 1'b1;
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for 4 requesters with per-grant hold limit and timeout pulse.
module decoder_rr_arbiter
  import decoder_rr_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic                 done,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic                 busy,
  output logic                 timeout
);

  state_t               r_state;
  logic [IDX_W-1:0]     r_ptr;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_gnt_idx;
  logic                 r_busy;
  logic                 r_timeout;
  logic [NUM_REQ-1:0]   r_gnt;

  state_t               w_state_nxt;
  logic [IDX_W-1:0]     w_ptr_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic                 w_busy_nxt;
  logic                 w_timeout_nxt;
  logic                 w_rel_limit;
  logic                 w_rel_other;
  logic [NUM_REQ-1:0]   w_gnt_nxt;

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = '0;
    w_idx_nxt     = r_gnt_idx;
    w_busy_nxt    = 1'b0;
    w_timeout_nxt = 1'b0;
    w_rel_limit   = (r_cnt == CNT_W'(HOLD_MAX - 1));
    w_rel_other   = done || !req[r_gnt_idx];
    unique case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_state_nxt = ST_GRANT;
          w_idx_nxt   = rr_pick(req, r_ptr);
          w_busy_nxt  = 1'b1;
        end
      end
      ST_GRANT: begin
        if (w_rel_limit || w_rel_other) begin
          w_state_nxt   = ST_IDLE;
          w_ptr_nxt     = r_gnt_idx + IDX_W'(1);
          // timeout only when the counter limit is the sole release cause
          w_timeout_nxt = w_rel_limit && !w_rel_other;
        end else begin
          w_busy_nxt = 1'b1;
          w_cnt_nxt  = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Decoding the next index/enable lets gnt be registered alongside gnt_idx.
  grant_decoder u_grant_decoder (
    .sel (w_idx_nxt),
    .en  (w_busy_nxt),
    .out (w_gnt_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_gnt_idx <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_gnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gnt_idx <= w_idx_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
      r_gnt     <= w_gnt_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_gnt_idx;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed self-checking bench for decoder_rr_arbiter (HOLD_MAX=8, CNT_W=4).
module tb_decoder_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  decoder_rr_arbiter #(.HOLD_MAX(8), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_idx,
                         input logic e_busy, input logic e_to);
    chk({tag, ".gnt"}, gnt, e_gnt);
    chk({tag, ".idx"}, {2'b00, gnt_idx}, {2'b00, e_idx});
    chk({tag, ".busy"}, {3'b000, busy}, {3'b000, e_busy});
    chk({tag, ".timeout"}, {3'b000, timeout}, {3'b000, e_to});
  endtask

  initial begin
    logic [3:0] oh;
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    tick();
    tick();
    chk_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // 1. idle with no requests
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all("idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    end

    // 2. rotation with done on the 2nd grant cycle
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      tick();
      chk_all("rr_c1", oh, 2'(k % 4), 1'b1, 1'b0);
      tick();
      chk_all("rr_c2", oh, 2'(k % 4), 1'b1, 1'b0);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk_all("rr_gap", 4'b0000, 2'(k % 4), 1'b0, 1'b0);
      if (k == 4) req = 4'b0100;
    end

    // 3. hold limit on requester 2
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_all("hold", 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    tick();
    chk_all("hold_to", 4'b0000, 2'd2, 1'b0, 1'b1);
    tick();
    chk_all("hold_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_all("hold_rel", 4'b0000, 2'd2, 1'b0, 1'b0);

    // 4. withdrawal by owner 3, then wrap to 0
    req = 4'b1000;
    tick();
    chk_all("wd_c1", 4'b1000, 2'd3, 1'b1, 1'b0);
    tick();
    chk_all("wd_c2", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    chk_all("wd_rel", 4'b0000, 2'd3, 1'b0, 1'b0);
    req = 4'b1001;
    tick();
    chk_all("wd_wrap", 4'b0001, 2'd0, 1'b1, 1'b0);

    // 5. done coincides with the hold limit
    for (int i = 1; i < 8; i++) begin
      tick();
      chk_all("sim_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 4'b0000;
    chk_all("sim_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    chk_all("sim_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // 6. reset during a grant to index 2
    req = 4'b0100;
    tick();
    chk_all("rst_g1", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick();
    chk_all("rst_g2", 4'b0100, 2'd2, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    chk_all("rst_mid", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    req = 4'b1111;
    tick();
    chk_all("rst_after", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
